stack_mem_master: RTL and testbench

//  Initiator side of the datapath's 8-bit data-memory port: turns push/pop/top requests

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_ptr_counter.sv | 45 ++++
 rtl/stack_mem_master.sv | 163 ++++++++++++++++
 tb/tb_stack_mem_master.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack memory initiator and the multi-cycle controller.
package stack_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 32;

  // FSM state encoding
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] WR   = 3'd1;
  localparam logic [2:0] RD   = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  // Accepted operation codes
  localparam logic [1:0] OP_PUSH = 2'd0;
  localparam logic [1:0] OP_POP  = 2'd1;
  localparam logic [1:0] OP_TOP  = 2'd2;

endpackage

// File: rtl/stack_ptr_counter.sv
// Stack pointer: saturating up/down counter over 0..DEPTH with occupancy flags.
module stack_ptr_counter
  import stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  input  logic            dec,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] cnt_q, cnt_d;

  // Next pointer value; refuses to step past either end so sp never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && (cnt_q != DEPTH_C)) begin
      cnt_d = cnt_q + ONE;
    end else if (dec && !inc && (cnt_q != '0)) begin
      cnt_d = cnt_q - ONE;
    end
  end

  // Pointer register with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign full  = (cnt_q == DEPTH_C);
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/stack_mem_master.sv
// Data-memory initiator: turns push/pop/top requests into one-cycle memory strobes.
//
// state | meaning
// IDLE  | waiting; the only state that samples push/pop/top
// WR    | write strobe on the bus, sp increments at the end of the cycle
// RD    | read strobe on the bus, dout captures mem_out, sp decrements on pop
// DONE  | one-cycle done pulse
// ERR   | one-cycle err pulse, request was rejected without touching memory
module stack_mem_master
  import stack_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              top,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_sig_write,
  output logic              mem_sig_read,
  input  logic [DATA_W-1:0] mem_out
);

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              wr_q, wr_d;
  logic              rd_q, rd_d;

  logic              req_any;
  logic              req_multi;
  logic              req_bad;
  logic              sp_inc;
  logic              sp_dec;
  logic [ADDR_W-1:0] sp_lo;

  stack_ptr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_sp (
    .clk   (clk),
    .clr   (rst),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign sp_lo = count[ADDR_W-1:0];

  // Request classification; only meaningful while IDLE
  always_comb begin
    req_any   = push | pop | top;
    req_multi = (push & pop) | (push & top) | (pop & top);
    req_bad   = req_multi | (push & full) | ((pop | top) & empty);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          if (req_bad)   state_d = ERR;
          else if (push) state_d = WR;
          else           state_d = RD;
        end
      end
      WR:      state_d = DONE;
      RD:      state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs and pointer steps
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    err    = (state_q == ERR);
    sp_inc = (state_q == WR);
    sp_dec = (state_q == RD) && (op_q == OP_POP);
  end

  // Bus register inputs: loaded on accept so strobe, address and data come
  // straight from flops for the whole WR/RD cycle, and fall to zero after it
  always_comb begin
    op_d       = op_q;
    dout_d     = dout_q;
    mem_adr_d  = '0;
    mem_data_d = '0;
    wr_d       = 1'b0;
    rd_d       = 1'b0;
    if ((state_q == IDLE) && req_any && !req_bad) begin
      if (push) begin
        op_d       = OP_PUSH;
        wr_d       = 1'b1;
        mem_adr_d  = sp_lo;
        mem_data_d = din;
      end else begin
        op_d      = pop ? OP_POP : OP_TOP;
        rd_d      = 1'b1;
        mem_adr_d = sp_lo - ONE_A;
      end
    end
    if (state_q == RD) begin
      dout_d = mem_out;
    end
  end

  // Datapath and bus registers
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= OP_PUSH;
      dout_q     <= '0;
      mem_adr_q  <= '0;
      mem_data_q <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      op_q       <= op_d;
      dout_q     <= dout_d;
      mem_adr_q  <= mem_adr_d;
      mem_data_q <= mem_data_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
    end
  end

  assign dout          = dout_q;
  assign mem_adr       = mem_adr_q;
  assign mem_data      = mem_data_q;
  assign mem_sig_write = wr_q;
  assign mem_sig_read  = rd_q;

endmodule

// File: tb/tb_stack_mem_master.sv
// Bench for stack_mem_master: data-memory model on the bus plus a queue-based stack model.
module tb_stack_mem_master;

  logic       clk = 1'b0;
  logic       rst, push, pop, top;
  logic [7:0] din, dout, mem_data, mem_out;
  logic       busy, done, err, full, empty, mem_sig_write, mem_sig_read;
  logic [5:0] count;
  logic [4:0] mem_adr;

  int n_checks = 0;
  int n_pass   = 0;
  bit both_hi  = 1'b0;

  logic [7:0] mem_arr [0:31];
  logic [7:0] mdl_q [$];
  logic [7:0] mdl_dout;

  typedef struct packed {
    logic       wr1, rd1, err1, done1, busy1;
    logic [4:0] adr1;
    logic [7:0] data1;
    logic       done2, err2, wr2, rd2;
    logic [5:0] cnt3;
    logic       empty3, full3, busy3;
    logic [7:0] dout3;
  } obs_t;

  always #5 clk = ~clk;

  stack_mem_master dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .pop           (pop),
    .top           (top),
    .din           (din),
    .dout          (dout),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .mem_adr       (mem_adr),
    .mem_data      (mem_data),
    .mem_sig_write (mem_sig_write),
    .mem_sig_read  (mem_sig_read),
    .mem_out       (mem_out)
  );

  always @(posedge clk) if (mem_sig_write) mem_arr[mem_adr] <= mem_data;
  assign mem_out = mem_sig_read ? mem_arr[mem_adr] : 8'h00;

  always @(negedge clk) if (mem_sig_write && mem_sig_read) both_hi = 1'b1;

  task automatic do_reset();
    rst = 1'b1; push = 1'b0; pop = 1'b0; top = 1'b0; din = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_q.delete();
    mdl_dout = 8'h00;
  endtask

  // Drives one request from IDLE, samples three cycles, and returns the
  // stack model's prediction alongside the observation.
  task automatic run_op(input logic p, input logic po, input logic t, input logic [7:0] d,
                        output obs_t o, output obs_t e);
    int sz, n;
    logic legal;
    sz = mdl_q.size();
    n = int'(p) + int'(po) + int'(t);
    legal = (n == 1) && !(p && sz == 32) && !((po || t) && sz == 0);
    e = '0;
    e.busy1 = 1'b1;
    e.err1  = !legal;
    e.wr1   = legal && p;
    e.rd1   = legal && !p;
    e.adr1  = !legal ? 5'd0 : (p ? 5'(sz) : 5'(sz - 1));
    e.data1 = (legal && p) ? d : 8'h00;
    e.done2 = legal;
    if (legal) begin
      if (p) begin
        mdl_q.push_back(d);
      end else begin
        mdl_dout = mdl_q[sz-1];
        if (po) void'(mdl_q.pop_back());
      end
    end
    e.cnt3   = 6'(mdl_q.size());
    e.empty3 = (mdl_q.size() == 0);
    e.full3  = (mdl_q.size() == 32);
    e.dout3  = mdl_dout;

    push = p; pop = po; top = t; din = d;
    @(posedge clk);
    #1 push = 1'b0; pop = 1'b0; top = 1'b0;
    o = '0;
    o.wr1 = mem_sig_write; o.rd1 = mem_sig_read; o.err1 = err; o.done1 = done;
    o.busy1 = busy; o.adr1 = mem_adr; o.data1 = mem_data;
    @(posedge clk);
    #1;
    o.done2 = done; o.err2 = err; o.wr2 = mem_sig_write; o.rd2 = mem_sig_read;
    @(posedge clk);
    #1;
    o.cnt3 = count; o.empty3 = empty; o.full3 = full; o.busy3 = busy; o.dout3 = dout;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (count !== 6'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if ({empty, full} !== 2'b10) $display("FAIL reset_flags got empty=%b full=%b want 1/0", empty, full); else n_pass++;
    n_checks++; if ({busy, done, err} !== 3'b000) $display("FAIL reset_status got busy/done/err=%b want 000", {busy, done, err}); else n_pass++;
    n_checks++; if ({mem_sig_write, mem_sig_read} !== 2'b00) $display("FAIL reset_strobes got %b want 00", {mem_sig_write, mem_sig_read}); else n_pass++;
    n_checks++; if ({mem_adr, mem_data, dout} !== 21'd0) $display("FAIL reset_bus got adr=%h data=%h dout=%h want 0", mem_adr, mem_data, dout); else n_pass++;
  endtask

  task automatic test_push_single();
    obs_t o, e;
    do_reset();
    run_op(1'b1, 1'b0, 1'b0, 8'hA5, o, e);
    n_checks++; if ({o.wr1, o.rd1, o.adr1, o.data1} !== {1'b1, 1'b0, 5'd0, 8'hA5}) $display("FAIL push_strobe got wr=%b rd=%b adr=%h data=%h want 1 0 00 a5", o.wr1, o.rd1, o.adr1, o.data1); else n_pass++;
    n_checks++; if ({o.done1, o.done2, o.wr2} !== 3'b010) $display("FAIL push_done got done1=%b done2=%b wr2=%b want 0 1 0", o.done1, o.done2, o.wr2); else n_pass++;
    n_checks++; if ({o.cnt3, o.empty3, o.busy3} !== {6'd1, 1'b0, 1'b0}) $display("FAIL push_count got cnt=%0d empty=%b busy=%b want 1 0 0", o.cnt3, o.empty3, o.busy3); else n_pass++;
  endtask

  task automatic test_push_pop();
    obs_t o, e;
    do_reset();
    run_op(1'b1, 1'b0, 1'b0, 8'h11, o, e);
    run_op(1'b1, 1'b0, 1'b0, 8'h22, o, e);
    run_op(1'b0, 1'b1, 1'b0, 8'h00, o, e);
    n_checks++; if ({o.rd1, o.wr1, o.adr1, o.dout3, o.cnt3} !== {1'b1, 1'b0, 5'd1, 8'h22, 6'd1}) $display("FAIL pop1 got rd=%b wr=%b adr=%0d dout=%h cnt=%0d want 1 0 1 22 1", o.rd1, o.wr1, o.adr1, o.dout3, o.cnt3); else n_pass++;
    run_op(1'b0, 1'b1, 1'b0, 8'h00, o, e);
    n_checks++; if ({o.rd1, o.adr1, o.dout3, o.done2} !== {1'b1, 5'd0, 8'h11, 1'b1}) $display("FAIL pop2 got rd=%b adr=%0d dout=%h done=%b want 1 0 11 1", o.rd1, o.adr1, o.dout3, o.done2); else n_pass++;
    n_checks++; if ({o.cnt3, o.empty3} !== {6'd0, 1'b1}) $display("FAIL pop_empty got cnt=%0d empty=%b want 0 1", o.cnt3, o.empty3); else n_pass++;
  endtask

  task automatic test_top();
    obs_t o, e;
    do_reset();
    run_op(1'b1, 1'b0, 1'b0, 8'h3C, o, e);
    for (int i = 0; i < 2; i++) begin
      run_op(1'b0, 1'b0, 1'b1, 8'hFF, o, e);
      n_checks++; if ({o.rd1, o.wr1, o.wr2, o.adr1, o.dout3, o.cnt3} !== {3'b100, 5'd0, 8'h3C, 6'd1}) $display("FAIL top%0d got rd=%b wr=%b/%b adr=%0d dout=%h cnt=%0d want 1 0/0 0 3c 1", i, o.rd1, o.wr1, o.wr2, o.adr1, o.dout3, o.cnt3); else n_pass++;
    end
  endtask

  task automatic test_fill_drain();
    obs_t o, e;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      run_op(1'b1, 1'b0, 1'b0, 8'(i), o, e);
      n_checks++; if ({o.wr1, o.adr1, o.full3} !== {1'b1, 5'(i), (i == 31)}) $display("FAIL fill%0d got wr=%b adr=%0d full=%b want 1 %0d %b", i, o.wr1, o.adr1, o.full3, i, i == 31); else n_pass++;
    end
    run_op(1'b1, 1'b0, 1'b0, 8'hEE, o, e);
    n_checks++; if ({o.err1, o.wr1, o.rd1, o.err2, o.done2} !== 5'b10000) $display("FAIL push_full got err=%b wr=%b rd=%b err2=%b done=%b want 1 0 0 0 0", o.err1, o.wr1, o.rd1, o.err2, o.done2); else n_pass++;
    n_checks++; if ({o.cnt3, o.full3} !== {6'd32, 1'b1}) $display("FAIL push_full_cnt got cnt=%0d full=%b want 32 1", o.cnt3, o.full3); else n_pass++;
    for (int i = 31; i >= 0; i--) begin
      run_op(1'b0, 1'b1, 1'b0, 8'h00, o, e);
      n_checks++; if ({o.adr1, o.dout3, o.cnt3} !== {5'(i), 8'(i), 6'(i)}) $display("FAIL drain%0d got adr=%0d dout=%h cnt=%0d want %0d", i, o.adr1, o.dout3, o.cnt3, i); else n_pass++;
    end
    n_checks++; if ({o.empty3, o.full3} !== 2'b10) $display("FAIL drain_flags got empty=%b full=%b want 1 0", o.empty3, o.full3); else n_pass++;
  endtask

  task automatic test_errors();
    obs_t o, e;
    logic [2:0] bad [4];
    bad[0] = 3'b010; bad[1] = 3'b110; bad[2] = 3'b001; bad[3] = 3'b111;
    do_reset();
    run_op(1'b1, 1'b0, 1'b0, 8'h5A, o, e);
    run_op(1'b0, 1'b1, 1'b0, 8'h00, o, e);
    for (int i = 0; i < 4; i++) begin
      run_op(bad[i][2], bad[i][1], bad[i][0], 8'h99, o, e);
      n_checks++; if ({o.err1, o.err2, o.wr1, o.rd1, o.done2} !== 5'b10000) $display("FAIL err%0d got err=%b/%b wr=%b rd=%b done=%b want 1/0 0 0 0", i, o.err1, o.err2, o.wr1, o.rd1, o.done2); else n_pass++;
      n_checks++; if ({o.cnt3, o.dout3} !== {6'd0, 8'h5A}) $display("FAIL err%0d_state got cnt=%0d dout=%h want 0 5a", i, o.cnt3, o.dout3); else n_pass++;
    end
  endtask

  task automatic test_rst_mid();
    obs_t o, e;
    do_reset();
    push = 1'b1; din = 8'h77;
    @(posedge clk);
    #1;
    n_checks++; if (mem_sig_write !== 1'b1) $display("FAIL rst_wr_active got %b want 1", mem_sig_write); else n_pass++;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; push = 1'b0;
    n_checks++; if ({busy, count, mem_sig_write, mem_sig_read, mem_adr} !== 14'd0) $display("FAIL rst_mid_wr got busy=%b cnt=%0d wr=%b rd=%b adr=%0d want all 0", busy, count, mem_sig_write, mem_sig_read, mem_adr); else n_pass++;
    mdl_q.delete(); mdl_dout = 8'h00;

    push = 1'b1; din = 8'h88;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 push = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    n_checks++; if ({count, busy, mem_sig_write} !== {6'd1, 2'b00}) $display("FAIL busy_ignore got cnt=%0d busy=%b wr=%b want 1 0 0", count, busy, mem_sig_write); else n_pass++;
    mdl_q.push_back(8'h88);

    pop = 1'b1;
    @(posedge clk);
    #1 pop = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if ({dout, count, mem_sig_read} !== {8'h00, 6'd0, 1'b0}) $display("FAIL rst_mid_rd got dout=%h cnt=%0d rd=%b want 00 0 0", dout, count, mem_sig_read); else n_pass++;
    mdl_q.delete(); mdl_dout = 8'h00;
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [2:0] combos [4];
    logic [2:0] req;
    int r;
    combos[0] = 3'b110; combos[1] = 3'b101; combos[2] = 3'b011; combos[3] = 3'b111;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      req = 3'b100;
      else if (r <= 6) req = 3'b010;
      else if (r <= 8) req = 3'b001;
      else             req = combos[$urandom_range(0, 3)];
      run_op(req[2], req[1], req[0], 8'($urandom), o, e);
      n_checks++; if (o !== e) $display("FAIL random%0d req=%b got %h want %h", i, req, o, e); else n_pass++;
    end
  endtask

  task automatic test_strobe_excl();
    n_checks++; if (both_hi !== 1'b0) $display("FAIL strobe_excl got both strobes high %b want 0", both_hi); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_push_pop();
    test_top();
    test_fill_drain();
    test_errors();
    test_rst_mid();
    test_random();
    test_strobe_excl();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
